vga_fb_scheduler: RTL and testbench

//  Owns the single-port 8-bit RGB332 framebuffer RAM that sits between the pixel

---
 rtl/vga_fb_scheduler.sv | 158 +++++++++++++++
 tb/tb_vga_fb_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : vga_fb_scheduler                                            |
// | Purpose    : Owns the single-port RGB332 framebuffer RAM port. Serves    |
// |              scan-position reads for the video driver with a fixed       |
// |              3-cycle latency, a whole-buffer clear-fill engine and host  |
// |              pixel writes. Priority: display read > fill > host write.   |
// | Ports      : CLOCK_50, reset_n    clock / async active-low reset        |
// |              x, y -> r, g, b      scan position in, 24-bit colour out   |
// |              wr_*                 host write valid/ready handshake      |
// |              fill_start/color/busy  clear-fill control                  |
// |              mem_*                registered RAM command, 1-cycle rdata  |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module vga_fb_scheduler #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int ADDR_W = 19
) (
   input  logic              CLOCK_50,
   input  logic              reset_n,
   input  logic [9:0]        x,
   input  logic [8:0]        y,
   output logic [7:0]        r,
   output logic [7:0]        g,
   output logic [7:0]        b,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [9:0]        wr_x,
   input  logic [8:0]        wr_y,
   input  logic [7:0]        wr_data,
   input  logic              fill_start,
   input  logic [7:0]        fill_color,
   output logic              fill_busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   output logic              mem_en,
   input  logic [7:0]        mem_rdata
);

   localparam logic [9:0]      X_LIM    = 10'(WIDTH);
   localparam logic [8:0]      Y_LIM    = 9'(HEIGHT);
   // One bit wider than the address so a buffer filling the whole address
   // space still has a distinct "finished" count.
   localparam logic [ADDR_W:0] FILL_LEN = (ADDR_W+1)'(WIDTH * HEIGHT);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } fill_state_t;

   fill_state_t       state;
   logic [18:0]       last_xy;
   logic [ADDR_W:0]   fill_cnt;
   logic [7:0]        fill_val;
   logic              disp_v1, disp_in1, disp_v2, disp_in2;

   logic              disp_req, disp_in, wr_in, fill_go, wr_fire;
   logic [ADDR_W-1:0] disp_addr, wr_addr;

   function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] px,
                                                  input logic [8:0] py);
      return ADDR_W'(py) * ADDR_W'(WIDTH) + ADDR_W'(px);
   endfunction

   function automatic logic [23:0] expand(input logic [7:0] p);
      return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], {4{p[1:0]}}};
   endfunction

   always_comb begin
      disp_req  = ({x, y} != last_xy);
      disp_in   = (x < X_LIM) && (y < Y_LIM);
      wr_in     = (wr_x < X_LIM) && (wr_y < Y_LIM);
      disp_addr = pix_addr(x, y);
      wr_addr   = pix_addr(wr_x, wr_y);
      // A fill starting on this edge takes precedence over a host write.
      fill_go   = fill_start && (state == ST_IDLE);
      wr_ready  = reset_n && !disp_req && !fill_busy && !fill_go;
      wr_fire   = wr_valid && wr_ready;
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         last_xy   <= '1;
         fill_cnt  <= '0;
         fill_val  <= '0;
         fill_busy <= 1'b0;
         disp_v1   <= 1'b0;
         disp_in1  <= 1'b0;
         disp_v2   <= 1'b0;
         disp_in2  <= 1'b0;
         r         <= '0;
         g         <= '0;
         b         <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         last_xy  <= {x, y};

         // Display pipeline: request -> RAM cycle -> rdata capture.
         disp_v1  <= disp_req;
         disp_in1 <= disp_req && disp_in;
         disp_v2  <= disp_v1;
         disp_in2 <= disp_in1;
         if (disp_v2) begin
            {r, g, b} <= disp_in2 ? expand(mem_rdata) : 24'h0;
         end

         // Slot arbitration for the next cycle.
         mem_en <= 1'b0;
         mem_we <= 1'b0;
         if (disp_req) begin
            mem_en   <= disp_in;
            mem_addr <= disp_addr;
         end else if ((state == ST_FILL) && (fill_cnt != FILL_LEN)) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= fill_cnt[ADDR_W-1:0];
            mem_wdata <= fill_val;
            fill_cnt  <= fill_cnt + 1'b1;
         end else if (wr_fire) begin
            // Out-of-range writes complete the handshake but touch nothing.
            mem_en    <= wr_in;
            mem_we    <= wr_in;
            mem_addr  <= wr_addr;
            mem_wdata <= wr_data;
         end

         // Fill FSM: busy drops on the edge after the last write is issued.
         case (state)
            ST_IDLE: begin
               if (fill_start) begin
                  state     <= ST_FILL;
                  fill_busy <= 1'b1;
                  fill_val  <= fill_color;
                  fill_cnt  <= '0;
               end
            end
            ST_FILL: begin
               if (fill_cnt == FILL_LEN) begin
                  state     <= ST_IDLE;
                  fill_busy <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               fill_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_vga_fb_scheduler                                         |
// | Purpose    : Self-checking bench for vga_fb_scheduler with an attached   |
// |              synchronous RAM and a transaction-level reference model.    |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_vga_fb_scheduler;

   localparam int WIDTH  = 640;
   localparam int HEIGHT = 8;
   localparam int ADDR_W = 13;
   localparam int NPIX   = WIDTH * HEIGHT;
   localparam int NMEM   = 2 ** ADDR_W;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [9:0]        x = '0;
   logic [8:0]        y = '0;
   logic [7:0]        r, g, b;
   logic              wr_valid = 1'b0;
   logic              wr_ready;
   logic [9:0]        wr_x = '0;
   logic [8:0]        wr_y = '0;
   logic [7:0]        wr_data = '0;
   logic              fill_start = 1'b0;
   logic [7:0]        fill_color = '0;
   logic              fill_busy;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic              mem_en;
   logic [7:0]        mem_rdata;

   vga_fb_scheduler #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) dut (
      .CLOCK_50  (clk),
      .reset_n   (reset_n),
      .x         (x),
      .y         (y),
      .r         (r),
      .g         (g),
      .b         (b),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_x      (wr_x),
      .wr_y      (wr_y),
      .wr_data   (wr_data),
      .fill_start(fill_start),
      .fill_color(fill_color),
      .fill_busy (fill_busy),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_en    (mem_en),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // Attached RAM: cleared on its first clock, read data one cycle later.
   logic [7:0] ram [0:NMEM-1];
   logic       ram_ready = 1'b0;
   int         dut_wr_cnt = 0;
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < NMEM; i++) ram[i] <= 8'h00;
         ram_ready <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr];
      end
      if (mem_en && mem_we) dut_wr_cnt <= dut_wr_cnt + 1;
   end

   // ---------------- reference model ----------------
   typedef struct {
      logic [9:0] x;
      logic [8:0] y;
      logic [7:0] d;
   } hw_t;
   hw_t hq[$];

   logic [7:0]  mram [0:NMEM-1];
   logic [18:0] prev_xy;
   logic [23:0] e_rgb, p0_val, p1_val;
   logic        p0_v, p1_v;
   logic        e_en, e_we, e_busy;
   int          e_addr, f_next;
   logic [7:0]  e_wdata, f_col;

   int total = 0;
   int bad   = 0;

   function automatic logic [23:0] expand(input logic [7:0] p);
      logic [2:0] r3, g3;
      logic [1:0] b2;
      r3 = p[7:5]; g3 = p[4:2]; b2 = p[1:0];
      return {r3, r3, r3[2:1], g3, g3, g3[2:1], b2, b2, b2, b2};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      prev_xy = '1;
      e_rgb = '0; p0_val = '0; p1_val = '0; p0_v = 1'b0; p1_v = 1'b0;
      e_en = 1'b0; e_we = 1'b0; e_busy = 1'b0;
      e_addr = 0; e_wdata = '0; f_next = 0; f_col = '0;
   endtask

   // Applies the rules for one clock edge using the inputs held across it.
   task automatic model_edge();
      bit req, inr, go, done, acc;
      int a, wa;
      if (!reset_n) begin
         model_reset();
         return;
      end
      if (p1_v) e_rgb = p1_val;
      p1_v = p0_v; p1_val = p0_val;
      req  = ({x, y} != prev_xy);
      prev_xy = {x, y};
      inr  = (int'(x) < WIDTH) && (int'(y) < HEIGHT);
      a    = int'(y) * WIDTH + int'(x);
      go   = fill_start && !e_busy;
      done = e_busy && (f_next == NPIX);
      acc  = wr_valid && !req && !e_busy && !go;
      p0_v = req;
      p0_val = 24'h0;
      if (req && inr) p0_val = expand(mram[a]);
      e_en = 1'b0; e_we = 1'b0;
      if (req) begin
         if (inr) begin e_en = 1'b1; e_addr = a; end
      end else if (e_busy && f_next < NPIX) begin
         e_en = 1'b1; e_we = 1'b1; e_addr = f_next; e_wdata = f_col;
         mram[f_next] = f_col;
         f_next++;
      end else if (acc) begin
         if (int'(wr_x) < WIDTH && int'(wr_y) < HEIGHT) begin
            wa = int'(wr_y) * WIDTH + int'(wr_x);
            e_en = 1'b1; e_we = 1'b1; e_addr = wa; e_wdata = wr_data;
            mram[wa] = wr_data;
         end
         hq.delete(0);
      end
      if (go) begin
         e_busy = 1'b1; f_col = fill_color; f_next = 0;
      end else if (done) begin
         e_busy = 1'b0;
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      chk("fill_busy", 32'(fill_busy), 32'(e_busy));
      chk("mem_en",    32'(mem_en),    32'(e_en));
      chk("mem_we",    32'(mem_we),    32'(e_we));
      if (e_en) chk("mem_addr", 32'(mem_addr), e_addr);
      if (e_en && e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      chk("rgb", 32'({r, g, b}), 32'(e_rgb));
      chk("wr_ready", 32'(wr_ready),
          32'(reset_n && ({x, y} == prev_xy) && !e_busy && !fill_start));
   end

   // ---------------- stimulus ----------------
   task automatic apply_host();
      if (hq.size() > 0) begin
         wr_valid = 1'b1; wr_x = hq[0].x; wr_y = hq[0].y; wr_data = hq[0].d;
      end else begin
         wr_valid = 1'b0;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      model_edge();
      apply_host();
   endtask

   task automatic push_wr(input int px, input int py, input logic [7:0] d);
      hw_t t;
      t.x = 10'(px); t.y = 9'(py); t.d = d;
      hq.push_back(t);
      apply_host();
   endtask

   task automatic wait_host(input int limit);
      for (int i = 0; i < limit && hq.size() > 0; i++) cycle();
      chk("host_drain", hq.size(), 0);
   endtask

   task automatic pix_check(input int px, input int py, input logic [23:0] exp_rgb,
                            input logic exp_en, input int exp_addr);
      x = 10'(px); y = 9'(py);
      cycle();
      @(negedge clk);
      chk("lit_en", 32'(mem_en), 32'(exp_en));
      if (exp_en) chk("lit_addr", 32'(mem_addr), exp_addr);
      cycle();
      cycle();
      @(negedge clk);
      chk("lit_rgb", 32'({r, g, b}), 32'(exp_rgb));
   endtask

   int sc = 0;
   int sx = 0;
   task automatic scan_step(input int row);
      if (sc % 2 == 0) begin
         sx = (sx + 1) % WIDTH;
         x = 10'(sx); y = 9'(row);
      end
      sc++;
      cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, cnt, it;
      for (int i = 0; i < NMEM; i++) mram[i] = 8'h00;
      model_reset();

      // Reset state
      repeat (3) cycle();
      @(negedge clk);
      chk("rst_fill_busy", 32'(fill_busy), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_rgb", 32'({r, g, b}), 0);
      reset_n = 1'b1;
      repeat (4) cycle();

      // Host write then read back through the display path
      push_wr(10, 2, 8'hE0);
      wait_host(10);
      pix_check(10, 2, 24'hFF0000, 1'b1, 1290);
      push_wr(1, 0, 8'h03);
      push_wr(2, 0, 8'h92);
      wait_host(10);
      pix_check(1, 0, 24'h0000FF, 1'b1, 1);
      pix_check(2, 0, 24'h9292AA, 1'b1, 2);

      // Out-of-range display and host accesses
      pix_check(700, 5, 24'h000000, 1'b0, 0);
      pix_check(5, 8, 24'h000000, 1'b0, 0);
      base = dut_wr_cnt;
      push_wr(640, 0, 8'h77);
      wait_host(10);
      @(negedge clk);
      chk("oor_wr_en", 32'(mem_en), 0);
      chk("oor_wr_cnt", dut_wr_cnt - base, 0);

      // Running scan with host writes queued behind it
      base = dut_wr_cnt;
      for (int i = 0; i < 6; i++) push_wr(20 + i, 4, 8'(8'h21 + 8'(i * 17)));
      for (int i = 0; i < 40; i++) scan_step(6);
      chk("gap_wr_drain", hq.size(), 0);
      chk("gap_wr_cnt", dut_wr_cnt - base, 6);
      chk("gap_wr_d0", 32'(ram[4 * WIDTH + 20]), 32'h21);
      chk("gap_wr_d5", 32'(ram[4 * WIDTH + 25]), 32'h76);

      // Fill with scan running; a same-edge host write must wait
      base = dut_wr_cnt;
      fill_start = 1'b1; fill_color = 8'h1C;
      push_wr(5, 5, 8'h1C);
      scan_step(7);
      fill_start = 1'b0; fill_color = 8'h00;
      it = 0;
      while (e_busy && it < 3 * NPIX) begin
         if (it == 200) begin fill_start = 1'b1; fill_color = 8'hFF; end
         if (it == 201) fill_start = 1'b0;
         scan_step(7);
         it++;
      end
      chk("fill_timeout", 32'(e_busy), 0);
      wait_host(10);
      repeat (2) cycle();
      @(negedge clk);
      chk("fill_busy_end", 32'(fill_busy), 0);
      cnt = 0;
      for (int i = 0; i < NPIX; i++) if (ram[i] == 8'h1C) cnt++;
      chk("fill_cover", cnt, NPIX);
      chk("fill_wr_cnt", dut_wr_cnt - base, NPIX + 1);

      // Reset pulsed mid-fill, with a host write pending
      fill_start = 1'b1; fill_color = 8'h55;
      scan_step(3);
      fill_start = 1'b0;
      for (int i = 0; i < 50; i++) scan_step(3);
      push_wr(7, 1, 8'h44);
      scan_step(3);
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_mid_busy", 32'(fill_busy), 0);
      chk("rst_mid_en", 32'(mem_en), 0);
      x = '0; y = '0;
      repeat (3) cycle();
      chk("rst_pending", hq.size(), 1);
      reset_n = 1'b1;
      cycle();
      @(negedge clk);
      chk("post_rst_en", 32'(mem_en), 1);
      chk("post_rst_addr", 32'(mem_addr), 0);
      wait_host(10);
      repeat (4) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
